// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and a single memory port, with wait states and an illegal-op trap.
module multicycle_control #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit EXT_OPS       = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       Neg,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       retire,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        LUI      = 4'd11,
        TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'd3;
    localparam logic [6:0] OP_STORE = 7'd35;
    localparam logic [6:0] OP_R     = 7'd51;
    localparam logic [6:0] OP_I     = 7'd19;
    localparam logic [6:0] OP_BR    = 7'd99;
    localparam logic [6:0] OP_JAL   = 7'd111;
    localparam logic [6:0] OP_LUI   = 7'd55;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    state_t     state_r;
    state_t     state_s;
    logic       done_s;
    logic       pc_write_s;
    logic       adr_src_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic       retire_s;
    logic       illegal_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [2:0] alu_ctrl_s;
    logic [2:0] imm_src_s;

    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic op5,
                                              input logic f7b5);
        logic [2:0] ctl;
        case (f3)
            3'b000:  ctl = (op5 && f7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  ctl = ALU_SLT;
            3'b110:  ctl = ALU_OR;
            3'b111:  ctl = ALU_AND;
            3'b100:  ctl = EXT_OPS ? ALU_XOR : ALU_ADD;
            3'b001:  ctl = EXT_OPS ? ALU_SLL : ALU_ADD;
            3'b101:  ctl = EXT_OPS ? ALU_SRL : ALU_ADD;
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

    // Flags come from rs1 - rs2; blt/bge use the raw MSB with no overflow correction.
    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic n);
        logic taken;
        case (f3)
            3'b000:  taken = z;
            3'b001:  taken = EXT_OPS ? !z : 1'b0;
            3'b100:  taken = EXT_OPS ? n : 1'b0;
            3'b101:  taken = EXT_OPS ? !n : 1'b0;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    assign done_s = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-state control decode.
    always_comb begin
        state_s      = state_r;
        pc_write_s   = 1'b0;
        adr_src_s    = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        retire_s     = 1'b0;
        illegal_s    = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_ctrl_s   = ALU_ADD;
        case (state_r)
            FETCH: begin
                mem_read_s   = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = done_s;
                pc_write_s   = done_s;
                state_s      = done_s ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_s = MEMADR;
                    OP_R:              state_s = EXECR;
                    OP_I:              state_s = EXECI;
                    OP_BR:             state_s = BRANCH;
                    OP_JAL:            state_s = JAL;
                    OP_LUI:            state_s = EXT_OPS ? LUI : TRAP;
                    default:           state_s = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                state_s     = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src_s  = 1'b1;
                mem_read_s = 1'b1;
                state_s    = done_s ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                state_s      = FETCH;
            end
            MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
                retire_s    = done_s;
                state_s     = done_s ? FETCH : MEMWRITE;
            end
            EXECR: begin
                alu_src_a_s = 2'b10;
                alu_ctrl_s  = alu_decode(funct3, op[5], funct7b5);
                state_s     = ALUWB;
            end
            EXECI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_ctrl_s  = alu_decode(funct3, op[5], funct7b5);
                state_s     = ALUWB;
            end
            LUI: begin
                alu_src_a_s = 2'b11;
                alu_src_b_s = 2'b01;
                state_s     = ALUWB;
            end
            ALUWB: begin
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
                state_s     = FETCH;
            end
            BRANCH: begin
                alu_src_a_s = 2'b10;
                alu_ctrl_s  = ALU_SUB;
                retire_s    = 1'b1;
                pc_write_s  = branch_taken(funct3, Zero, Neg);
                state_s     = FETCH;
            end
            JAL: begin
                // PC <- target held in ALUOut; ALU forms OldPC+4 for the link write.
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_write_s  = 1'b1;
                state_s     = ALUWB;
            end
            TRAP: begin
                illegal_s = 1'b1;
                state_s   = TRAP;
            end
            default: begin
                illegal_s = 1'b1;
                state_s   = TRAP;
            end
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (op)
            OP_STORE: imm_src_s = 3'b001;
            OP_BR:    imm_src_s = 3'b010;
            OP_JAL:   imm_src_s = 3'b011;
            OP_LUI:   imm_src_s = 3'b100;
            default:  imm_src_s = 3'b000;
        endcase
    end

    // Enables are gated by rst_n so nothing writes while reset is held.
    assign PCWrite    = pc_write_s  & rst_n;
    assign MemRead    = mem_read_s  & rst_n;
    assign MemWrite   = mem_write_s & rst_n;
    assign IRWrite    = ir_write_s  & rst_n;
    assign RegWrite   = reg_write_s & rst_n;
    assign retire     = retire_s    & rst_n;
    assign illegal    = illegal_s   & rst_n;
    assign AdrSrc     = adr_src_s;
    assign ResultSrc  = result_src_s;
    assign ALUSrcA    = alu_src_a_s;
    assign ALUSrcB    = alu_src_b_s;
    assign ALUControl = alu_ctrl_s;
    assign ImmSrc     = imm_src_s;

endmodule
